// File: rtl/sodor5_itype_commit_checker_if.sv
// Bundle of the issue, writeback, shadow-init and failure-report signals between
// the sodor5 verification harness (master) and the I-type commit checker (slave).
interface sodor5_itype_commit_checker_if #(
    parameter int WORD_SIZE  = 32,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 init_we;
    logic [4:0]           init_addr;
    logic [WORD_SIZE-1:0] init_data;

    logic                 issue_valid;
    logic [31:0]          issue_instr;
    logic                 issue_ready;

    logic                 wb_valid;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;

    logic                 fail;
    logic [1:0]           fail_code;
    logic [4:0]           fail_rd;
    logic [WORD_SIZE-1:0] fail_exp;
    logic [WORD_SIZE-1:0] fail_got;
    logic [31:0]          checked_count;
    logic [CNT_W-1:0]     pending_count;

    modport master (
        output init_we, init_addr, init_data,
        output issue_valid, issue_instr,
        input  issue_ready,
        output wb_valid, wb_rd, wb_data,
        input  fail, fail_code, fail_rd, fail_exp, fail_got,
        input  checked_count, pending_count
    );

    modport slave (
        input  init_we, init_addr, init_data,
        input  issue_valid, issue_instr,
        output issue_ready,
        input  wb_valid, wb_rd, wb_data,
        output fail, fail_code, fail_rd, fail_exp, fail_got,
        output checked_count, pending_count
    );
endinterface

// File: rtl/sodor5_itype_commit_checker.sv
// Shadow-executes OP-IMM instructions issued to the sodor5 core, queues the expected
// writebacks in program order and latches the first writeback that disagrees.
module sodor5_itype_commit_checker #(
    parameter int NUM_REGS   = 32,
    parameter int WORD_SIZE  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input logic                            clk,
    input logic                            reset,
    sodor5_itype_commit_checker_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_CHECK,
        ST_FAIL
    } state_t;

    state_t               r_state;
    logic [WORD_SIZE-1:0] r_shadow [NUM_REGS];
    logic [4:0]           r_fifoRd   [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] r_fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_fail;
    logic [1:0]           r_failCode;
    logic [4:0]           r_failRd;
    logic [WORD_SIZE-1:0] r_failExp;
    logic [WORD_SIZE-1:0] r_failGot;
    logic [31:0]          r_checkedCount;

    logic                        w_issueReady;
    logic                        w_accept;
    logic                        w_isOpImm;
    logic [4:0]                  w_rd;
    logic [4:0]                  w_rs1;
    logic [2:0]                  w_funct3;
    logic [4:0]                  w_shamt;
    logic [WORD_SIZE-1:0]        w_imm;
    logic [WORD_SIZE-1:0]        w_rs1Val;
    logic signed [WORD_SIZE-1:0] w_sra;
    logic [WORD_SIZE-1:0]        w_result;
    logic                        w_push;
    logic                        w_wbLive;
    logic                        w_wbEmpty;
    logic                        w_pop;
    logic [4:0]                  w_headRd;
    logic [WORD_SIZE-1:0]        w_headData;
    logic                        w_match;
    logic                        w_waiting;
    logic                        w_timeout;

    // Ready is forced low while reset is held so every output reads 0 during reset.
    assign w_issueReady = reset && (r_state == ST_CHECK) && !bus.init_we &&
                          (r_count < CNT_W'(FIFO_DEPTH));
    assign w_accept     = bus.issue_valid && w_issueReady;

    assign w_isOpImm = (bus.issue_instr[6:0] == 7'b0010011);
    assign w_rd      = bus.issue_instr[11:7];
    assign w_funct3  = bus.issue_instr[14:12];
    assign w_rs1     = bus.issue_instr[19:15];
    assign w_shamt   = bus.issue_instr[24:20];
    assign w_imm     = {{(WORD_SIZE-12){bus.issue_instr[31]}}, bus.issue_instr[31:20]};
    assign w_rs1Val  = r_shadow[w_rs1];
    assign w_sra     = $signed(w_rs1Val) >>> w_shamt;

    always_comb begin
        w_result = '0;
        case (w_funct3)
            3'd0: w_result = w_rs1Val + w_imm;
            3'd1: w_result = w_rs1Val << w_shamt;
            3'd2: w_result = {{(WORD_SIZE-1){1'b0}}, ($signed(w_rs1Val) < $signed(w_imm))};
            3'd3: w_result = {{(WORD_SIZE-1){1'b0}}, (w_rs1Val < w_imm)};
            3'd4: w_result = w_rs1Val ^ w_imm;
            3'd5: w_result = bus.issue_instr[30] ? w_sra : (w_rs1Val >> w_shamt);
            3'd6: w_result = w_rs1Val | w_imm;
            3'd7: w_result = w_rs1Val & w_imm;
        endcase
    end

    assign w_push = w_accept && w_isOpImm && (w_rd != 5'd0);

    // Writebacks are judged against occupancy before this edge; a same-cycle push cannot satisfy one.
    assign w_wbLive   = (r_state == ST_CHECK) && bus.wb_valid && (bus.wb_rd != 5'd0);
    assign w_wbEmpty  = w_wbLive && (r_count == '0);
    assign w_pop      = w_wbLive && (r_count != '0);
    assign w_headRd   = r_fifoRd[r_rdPtr];
    assign w_headData = r_fifoData[r_rdPtr];
    assign w_match    = w_pop && (w_headRd == bus.wb_rd) && (w_headData == bus.wb_data);

    assign w_waiting = (r_state == ST_CHECK) && (r_count != '0) && !w_pop;
    assign w_timeout = w_waiting && ((r_timer + 1'b1) == TMR_W'(TIMEOUT));

    // Queue storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoRd[r_wrPtr]   <= w_rd;
            r_fifoData[r_wrPtr] <= w_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_CHECK;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
            end
            r_wrPtr        <= '0;
            r_rdPtr        <= '0;
            r_count        <= '0;
            r_timer        <= '0;
            r_fail         <= 1'b0;
            r_failCode     <= 2'd0;
            r_failRd       <= 5'd0;
            r_failExp      <= '0;
            r_failGot      <= '0;
            r_checkedCount <= '0;
        end else begin
            if (bus.init_we && (bus.init_addr != 5'd0)) begin
                r_shadow[bus.init_addr] <= bus.init_data;
            end
            if (w_push) begin
                r_shadow[w_rd] <= w_result;
            end

            case (r_state)
                ST_CHECK: begin
                    if (w_push) begin
                        r_wrPtr <= r_wrPtr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rdPtr <= r_rdPtr + 1'b1;
                    end
                    if (w_push && !w_pop) begin
                        r_count <= r_count + 1'b1;
                    end else if (!w_push && w_pop) begin
                        r_count <= r_count - 1'b1;
                    end

                    r_timer <= w_waiting ? r_timer + 1'b1 : '0;

                    if (w_match) begin
                        r_checkedCount <= r_checkedCount + 32'd1;
                    end

                    if (w_wbEmpty) begin
                        r_state    <= ST_FAIL;
                        r_fail     <= 1'b1;
                        r_failCode <= 2'd2;
                        r_failRd   <= bus.wb_rd;
                        r_failExp  <= '0;
                        r_failGot  <= bus.wb_data;
                    end else if (w_pop && !w_match) begin
                        r_state    <= ST_FAIL;
                        r_fail     <= 1'b1;
                        r_failCode <= 2'd1;
                        r_failRd   <= w_headRd;
                        r_failExp  <= w_headData;
                        r_failGot  <= bus.wb_data;
                    end else if (w_timeout) begin
                        r_state    <= ST_FAIL;
                        r_fail     <= 1'b1;
                        r_failCode <= 2'd3;
                        r_failRd   <= w_headRd;
                        r_failExp  <= w_headData;
                        r_failGot  <= '0;
                    end
                end
                ST_FAIL: begin
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_state <= ST_FAIL;
                end
            endcase
        end
    end

    assign bus.issue_ready   = w_issueReady;
    assign bus.fail          = r_fail;
    assign bus.fail_code     = r_failCode;
    assign bus.fail_rd       = r_failRd;
    assign bus.fail_exp      = r_failExp;
    assign bus.fail_got      = r_failGot;
    assign bus.checked_count = r_checkedCount;
    assign bus.pending_count = r_count;
endmodule

// File: tb/tb_sodor5_itype_commit_checker.sv
// Directed bench for the I-type commit checker: hand-encoded OP-IMM instructions
// with hand-computed shadow results, writeback matches/mismatches, backpressure and timeout.
module tb_sodor5_itype_commit_checker;
    logic clk;
    logic reset;
    int   compareCount;
    int   failCount;

    sodor5_itype_commit_checker_if #(.WORD_SIZE(32), .FIFO_DEPTH(8)) bus ();

    sodor5_itype_commit_checker #(
        .NUM_REGS(32), .WORD_SIZE(32), .FIFO_DEPTH(8), .TIMEOUT(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic doIssue, input logic [31:0] instr,
                                 input logic doWb, input logic [4:0] rd,
                                 input logic [31:0] data);
        bus.issue_valid = doIssue;
        bus.issue_instr = instr;
        bus.wb_valid    = doWb;
        bus.wb_rd       = rd;
        bus.wb_data     = data;
        tick();
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
    endtask

    task automatic loadShadow(input logic [4:0] addr, input logic [31:0] data);
        bus.init_we   = 1'b1;
        bus.init_addr = addr;
        bus.init_data = data;
        tick();
        bus.init_we   = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compareCount    = 0;
        failCount       = 0;
        reset           = 1'b0;
        bus.init_we     = 1'b0;
        bus.init_addr   = 5'd0;
        bus.init_data   = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_instr = 32'd0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.wb_data     = 32'd0;

        tick();
        tick();
        checkOutput("rst_fail",    32'(bus.fail), 32'd0);
        checkOutput("rst_pending", 32'(bus.pending_count), 32'd0);
        checkOutput("rst_ready",   32'(bus.issue_ready), 32'd0);
        checkOutput("rst_checked", bus.checked_count, 32'd0);
        checkOutput("rst_code",    32'(bus.fail_code), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("ready_after_rst", 32'(bus.issue_ready), 32'd1);

        // ADDI x2,x1,-1 with x1=5 -> 4
        loadShadow(5'd1, 32'h0000_0005);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        checkOutput("addi_pending", 32'(bus.pending_count), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd2, 32'h0000_0004);
        checkOutput("addi_checked", bus.checked_count, 32'd1);
        checkOutput("addi_fail",    32'(bus.fail), 32'd0);
        checkOutput("addi_drained", 32'(bus.pending_count), 32'd0);

        // SRAI x4,x3,4 with x3=0x80000000 -> 0xF8000000
        loadShadow(5'd3, 32'h8000_0000);
        applyStimulus(1'b1, 32'h4041_D213, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd4, 32'hF800_0000);
        checkOutput("srai_checked", bus.checked_count, 32'd2);

        // SLTI x7,x1,6 -> 1 ; SLTIU x8,x3,-1 -> 1 ; XORI x9,x2,0xF0 -> 0xF4 ; SRLI x10,x3,4 -> 0x08000000
        applyStimulus(1'b1, 32'h0060_A393, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'hFFF1_B413, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'h0F01_4493, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'h0041_D513, 1'b0, 5'd0, 32'd0);
        checkOutput("four_pending", 32'(bus.pending_count), 32'd4);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd7,  32'h0000_0001);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd8,  32'h0000_0001);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd9,  32'h0000_00F4);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd10, 32'h0800_0000);
        checkOutput("four_checked", bus.checked_count, 32'd6);
        checkOutput("four_fail",    32'(bus.fail), 32'd0);

        // NOP and a non-OP-IMM instruction queue nothing; WB to x0 is ignored
        applyStimulus(1'b1, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'h0020_81B3, 1'b1, 5'd0, 32'hDEAD_BEEF);
        checkOutput("nop_pending", 32'(bus.pending_count), 32'd0);
        checkOutput("nop_fail",    32'(bus.fail), 32'd0);

        // SRAI again but core returns the logical-shift value
        applyStimulus(1'b1, 32'h4041_D213, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd4, 32'h0800_0000);
        checkOutput("mm_fail",    32'(bus.fail), 32'd1);
        checkOutput("mm_code",    32'(bus.fail_code), 32'd1);
        checkOutput("mm_rd",      32'(bus.fail_rd), 32'd4);
        checkOutput("mm_exp",     bus.fail_exp, 32'hF800_0000);
        checkOutput("mm_got",     bus.fail_got, 32'h0800_0000);
        checkOutput("mm_checked", bus.checked_count, 32'd6);
        checkOutput("mm_ready",   32'(bus.issue_ready), 32'd0);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        checkOutput("mm_frozen",  32'(bus.pending_count), 32'd0);

        // Backpressure: x1=0 after reset, so every ADDI x2,x1,-1 expects 0xFFFFFFFF
        doReset();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("bp_ready%0d", i), 32'(bus.issue_ready), 32'd1);
            applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        end
        checkOutput("bp_full_pending", 32'(bus.pending_count), 32'd8);
        checkOutput("bp_full_ready",   32'(bus.issue_ready), 32'd0);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        checkOutput("bp_ninth_blocked", 32'(bus.pending_count), 32'd8);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd2, 32'hFFFF_FFFF);
        checkOutput("bp_one_wb_ready",   32'(bus.issue_ready), 32'd1);
        checkOutput("bp_one_wb_pending", 32'(bus.pending_count), 32'd7);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        checkOutput("bp_refill", 32'(bus.pending_count), 32'd8);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 5'd2, 32'hFFFF_FFFF);
        end
        checkOutput("bp_drain_pending", 32'(bus.pending_count), 32'd1);
        checkOutput("bp_drain_checked", bus.checked_count, 32'd8);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b1, 5'd2, 32'hFFFF_FFFF);
        checkOutput("bp_pushpop_pending", 32'(bus.pending_count), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd2, 32'hFFFF_FFFF);
        checkOutput("bp_final_checked", bus.checked_count, 32'd10);
        checkOutput("bp_final_pending", 32'(bus.pending_count), 32'd0);
        checkOutput("bp_final_fail",    32'(bus.fail), 32'd0);

        // Writeback with nothing queued
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
        checkOutput("empty_fail",  32'(bus.fail), 32'd1);
        checkOutput("empty_code",  32'(bus.fail_code), 32'd2);
        checkOutput("empty_rd",    32'(bus.fail_rd), 32'd5);
        checkOutput("empty_exp",   bus.fail_exp, 32'd0);
        checkOutput("empty_got",   bus.fail_got, 32'h0000_1234);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        checkOutput("empty_no_issue", 32'(bus.pending_count), 32'd0);
        checkOutput("empty_ready",    32'(bus.issue_ready), 32'd0);

        // Timeout: ADDI x6,x0,7 pushed, then 64 edges with no writeback
        doReset();
        applyStimulus(1'b1, 32'h0070_0313, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 63; i++) begin
            tick();
        end
        checkOutput("to_before", 32'(bus.fail), 32'd0);
        tick();
        checkOutput("to_fail", 32'(bus.fail), 32'd1);
        checkOutput("to_code", 32'(bus.fail_code), 32'd3);
        checkOutput("to_rd",   32'(bus.fail_rd), 32'd6);
        checkOutput("to_exp",  bus.fail_exp, 32'd7);
        checkOutput("to_got",  bus.fail_got, 32'd0);

        // Async reset mid-run with 3 pending, then shadow must read back zero
        doReset();
        loadShadow(5'd1, 32'h0000_0005);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        checkOutput("mid_pending_before", 32'(bus.pending_count), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_pending_async", 32'(bus.pending_count), 32'd0);
        checkOutput("mid_fail_async",    32'(bus.fail), 32'd0);
        checkOutput("mid_ready_async",   32'(bus.issue_ready), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(1'b1, 32'hFFF0_8113, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 5'd2, 32'hFFFF_FFFF);
        checkOutput("mid_shadow_cleared", bus.checked_count, 32'd1);
        checkOutput("mid_shadow_fail",    32'(bus.fail), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
